// File: rtl/simon_pkg.sv
// Shared types and defaults for the Simon sequence controller.
// Consumed by simon_seq_fsm and simon_speed_ramp.
package simon_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        SHOW_ON,
        SHOW_OFF,
        INPUT,
        CHECK,
        NEXT,
        WIN,
        LOSE
    } simon_state_e;

    localparam int N_ROUNDS_DEF         = 32;
    localparam int ROUND_W_DEF          = 6;
    localparam int SPEED_W_DEF          = 3;
    localparam int ROUNDS_PER_SPEED_DEF = 4;
    localparam int TIMEOUT_PULSES_DEF   = 8;

    // A game is in progress everywhere except the three resting states.
    function automatic logic state_busy(simon_state_e s);
        return !(s inside {IDLE, WIN, LOSE});
    endfunction

endpackage

// File: rtl/simon_speed_ramp.sv
// Speed level for the flash timer: steps up once every ROUNDS_PER_SPEED
// rounds and saturates at its all-ones value.
module simon_speed_ramp
    import simon_pkg::*;
#(
    parameter int SPEED_W          = SPEED_W_DEF,
    parameter int ROUNDS_PER_SPEED = ROUNDS_PER_SPEED_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc_round,
    output logic [SPEED_W-1:0] speed
);

    localparam int CW = (ROUNDS_PER_SPEED > 1) ? $clog2(ROUNDS_PER_SPEED) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ROUNDS_PER_SPEED - 1);
    // A cleared game starts at round 1, so the phase starts at 1 mod period.
    localparam logic [CW-1:0] CNT_INIT = CW'(1 % ROUNDS_PER_SPEED);
    localparam logic [SPEED_W-1:0] SPD_MAX = '1;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [SPEED_W-1:0] speed_q, speed_d;

    // Track round number modulo the period and bump speed on wrap.
    always_comb begin
        cnt_d   = cnt_q;
        speed_d = speed_q;
        if (clr) begin
            cnt_d   = CNT_INIT;
            speed_d = '0;
        end else if (inc_round) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (speed_q != SPD_MAX) begin
                    speed_d = speed_q + SPEED_W'(1);
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Phase counter and speed registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            speed_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            speed_q <= speed_d;
        end
    end

    assign speed = speed_q;

endmodule

// File: rtl/simon_seq_fsm.sv
// Simon game sequencer: show the colour sequence, collect presses, judge.
// Optional macro SIMON_TIMEOUT_EN adds an INPUT-phase pulse timeout.
module simon_seq_fsm
    import simon_pkg::*;
#(
    parameter int N_ROUNDS         = N_ROUNDS_DEF,
    parameter int ROUND_W          = ROUND_W_DEF,
    parameter int SPEED_W          = SPEED_W_DEF,
    parameter int ROUNDS_PER_SPEED = ROUNDS_PER_SPEED_DEF
`ifdef SIMON_TIMEOUT_EN
    ,
    parameter int TIMEOUT_PULSES   = TIMEOUT_PULSES_DEF
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_btn,
    input  logic               btn_valid,
    input  logic               result,
    input  logic               pulse,
    output logic               start,
    output logic               load_colour,
    output logic               load_speed,
    output logic               rst_seedgen,
    output logic               flash_clk,
    output logic [ROUND_W-1:0] check_round,
    output logic [ROUND_W-1:0] step_idx,
    output logic [SPEED_W-1:0] speed,
    output logic               win,
    output logic               lose,
    output logic               busy
);

    localparam logic [ROUND_W-1:0] R_ONE  = ROUND_W'(1);
    localparam logic [ROUND_W-1:0] R_LAST = ROUND_W'(N_ROUNDS);

    simon_state_e       state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [ROUND_W-1:0] step_q, step_d;
    logic               last_step;

    logic start_q, start_d;
    logic load_q, load_d;
    logic flash_q, flash_d;
    logic seed_q, seed_d;
    logic win_q, win_d;
    logic lose_q, lose_d;
    logic busy_q, busy_d;

    logic ramp_clr;
    logic ramp_inc;

`ifdef SIMON_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_PULSES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_PULSES - 1);
    logic [TW-1:0] to_q, to_d;
`endif

    assign last_step = (step_q == round_q - R_ONE);
    assign ramp_clr  = (state_q == IDLE) && start_btn;
    assign ramp_inc  = (state_q == NEXT);

    simon_speed_ramp #(
        .SPEED_W          (SPEED_W),
        .ROUNDS_PER_SPEED (ROUNDS_PER_SPEED)
    ) u_ramp (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (ramp_clr),
        .inc_round (ramp_inc),
        .speed     (speed)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            round_q <= '0;
            step_q  <= '0;
            start_q <= 1'b0;
            load_q  <= 1'b0;
            flash_q <= 1'b0;
            seed_q  <= 1'b1;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SIMON_TIMEOUT_EN
            to_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            step_q  <= step_d;
            start_q <= start_d;
            load_q  <= load_d;
            flash_q <= flash_d;
            seed_q  <= seed_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
            busy_q  <= busy_d;
`ifdef SIMON_TIMEOUT_EN
            to_q    <= to_d;
`endif
        end
    end

    // Next state and counter updates.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        step_d  = step_q;
`ifdef SIMON_TIMEOUT_EN
        to_d    = to_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_btn) begin
                    state_d = LOAD;
                    round_d = R_ONE;
                    step_d  = '0;
                end
            end
            LOAD: state_d = SHOW_ON;
            SHOW_ON: begin
                if (pulse) state_d = SHOW_OFF;
            end
            SHOW_OFF: begin
                if (pulse) begin
                    if (last_step) begin
                        step_d  = '0;
                        state_d = INPUT;
`ifdef SIMON_TIMEOUT_EN
                        to_d    = '0;
`endif
                    end else begin
                        step_d  = step_q + R_ONE;
                        state_d = LOAD;
                    end
                end
            end
            INPUT: begin
                // A press beats a simultaneous timer tick.
                if (btn_valid) begin
                    state_d = CHECK;
`ifdef SIMON_TIMEOUT_EN
                    to_d    = '0;
                end else if (pulse) begin
                    if (to_q == TO_LAST) begin
                        state_d = LOSE;
                    end else begin
                        to_d = to_q + TW'(1);
                    end
`endif
                end
            end
            CHECK: begin
                if (!result) begin
                    state_d = LOSE;
                end else if (!last_step) begin
                    step_d  = step_q + R_ONE;
                    state_d = INPUT;
                end else if (round_q == R_LAST) begin
                    state_d = WIN;
                end else begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                round_d = round_q + R_ONE;
                step_d  = '0;
                state_d = LOAD;
            end
            WIN, LOSE: begin
                if (start_btn) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state being entered.
    always_comb begin
        start_d = (state_q == IDLE) && (state_d == LOAD);
        load_d  = (state_d == LOAD);
        flash_d = (state_d == SHOW_ON);
        seed_d  = (state_d == IDLE);
        win_d   = (state_d == WIN);
        lose_d  = (state_d == LOSE);
        busy_d  = state_busy(state_d);
    end

    assign start       = start_q;
    assign load_colour = load_q;
    assign load_speed  = load_q;
    assign rst_seedgen = seed_q;
    assign flash_clk   = flash_q;
    assign check_round = round_q;
    assign step_idx    = step_q;
    assign win         = win_q;
    assign lose        = lose_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_simon_seq_fsm.sv
// Randomized scoreboard bench for simon_seq_fsm.
// Exercises the SIMON_TIMEOUT_EN build too when that macro is defined.
module tb_simon_seq_fsm;

    localparam int N   = 9;
    localparam int RW  = 4;
    localparam int SW  = 2;
    localparam int RPS = 2;

    logic clk = 1'b0;
    logic rst_n, start_btn, btn_valid, result, pulse;
    logic start, load_colour, load_speed, rst_seedgen, flash_clk;
    logic win, lose, busy;
    logic [RW-1:0] check_round, step_idx;
    logic [SW-1:0] speed;

    int n_checks = 0;
    int n_errors = 0;
    bit stop_all = 0;

    // kind: 0 flash, 1 win, 2 lose
    typedef struct {
        int kind;
        int rnd;
        int step;
        int spd;
        int first;
    } ev_t;
    ev_t sb[$];

    always #5 clk = ~clk;

    simon_seq_fsm #(
        .N_ROUNDS         (N),
        .ROUND_W          (RW),
        .SPEED_W          (SW),
        .ROUNDS_PER_SPEED (RPS)
`ifdef SIMON_TIMEOUT_EN
        ,
        .TIMEOUT_PULSES   (8)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_btn   (start_btn),
        .btn_valid   (btn_valid),
        .result      (result),
        .pulse       (pulse),
        .start       (start),
        .load_colour (load_colour),
        .load_speed  (load_speed),
        .rst_seedgen (rst_seedgen),
        .flash_clk   (flash_clk),
        .check_round (check_round),
        .step_idx    (step_idx),
        .speed       (speed),
        .win         (win),
        .lose        (lose),
        .busy        (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got timeout expected event", name);
        stop_all = 1;
    endtask

    // Reference speed: one level per RPS rounds, capped at all-ones.
    function automatic int exp_speed(input int r);
        int s;
        int mx;
        s  = r / RPS;
        mx = (1 << SW) - 1;
        return (s > mx) ? mx : s;
    endfunction

    task automatic push_round(input int r);
        for (int s = 0; s < r; s++) begin
            sb.push_back('{kind: 0, rnd: r, step: s,
                           spd: exp_speed(r),
                           first: (r == 1 && s == 0) ? 1 : 0});
        end
    endtask

    task automatic push_end(input int kind, input int r);
        sb.push_back('{kind: kind, rnd: r, step: 0, spd: 0, first: 0});
    endtask

    task automatic pop_ev(input string what, output ev_t e, output bit ok);
        ok = 0;
        e  = '{kind: -1, rnd: 0, step: 0, spd: 0, first: 0};
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got unexpected event expected none", what);
        end else begin
            e  = sb.pop_front();
            ok = 1;
        end
    endtask

    // Monitor: pop an expectation whenever the DUT presents an event.
    logic win_p = 1'b0;
    logic lose_p = 1'b0;
    always @(negedge clk) begin : monitor
        ev_t e;
        bit ok;
        if (rst_n === 1'b1) begin
            if (load_colour || start) begin
                pop_ev("flash_event", e, ok);
                if (ok) begin
                    chk("flash_kind", 0, e.kind);
                    chk("flash_round", int'(check_round), e.rnd);
                    chk("flash_step", int'(step_idx), e.step);
                    chk("flash_speed", int'(speed), e.spd);
                    chk("start_pulse", int'(start), e.first);
                    chk("load_colour", int'(load_colour), 1);
                    chk("load_speed", int'(load_speed), 1);
                end
            end
            if (win && !win_p) begin
                pop_ev("win_event", e, ok);
                if (ok) begin
                    chk("win_kind", 1, e.kind);
                    chk("win_round", int'(check_round), e.rnd);
                end
            end
            if (lose && !lose_p) begin
                pop_ev("lose_event", e, ok);
                if (ok) begin
                    chk("lose_kind", 2, e.kind);
                    chk("lose_round", int'(check_round), e.rnd);
                end
            end
        end
        win_p  = win;
        lose_p = lose;
    end

    function automatic logic rbit();
        return $urandom_range(0, 1) == 1;
    endfunction

    task automatic wait_flash(output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (flash_clk) begin
                ok = 1;
                break;
            end
            btn_valid = rbit();
            start_btn = rbit();
            @(negedge clk);
        end
        btn_valid = 1'b0;
        start_btn = 1'b0;
        if (!ok) fail_now("wait_flash");
    endtask

    task automatic noisy_wait();
        repeat ($urandom_range(0, 3)) begin
            btn_valid = rbit();
            start_btn = rbit();
            @(negedge clk);
        end
        btn_valid = 1'b0;
        start_btn = 1'b0;
    endtask

    // Drive pulses through all flashes of round r; abort on request.
    task automatic show_round(input int r, input bit abort, output bit ok);
        ok = 0;
        for (int s = 0; s < r; s++) begin
            wait_flash(ok);
            if (!ok) return;
            if (abort) begin
                rst_n = 1'b0;
                sb.delete();
                @(negedge clk);
                chk("rst_seedgen", int'(rst_seedgen), 1);
                chk("rst_round", int'(check_round), 0);
                chk("rst_flash", int'(flash_clk), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_speed", int'(speed), 0);
                rst_n = 1'b1;
                @(negedge clk);
                ok = 0;
                return;
            end
            noisy_wait();
            pulse = 1'b1;
            @(negedge clk);
            pulse = 1'b0;
            chk("show_off_flash", int'(flash_clk), 0);
            noisy_wait();
            pulse = 1'b1;
            @(negedge clk);
            pulse = 1'b0;
        end
        ok = 1;
    endtask

    // Collect r presses; returns lost=1 if a wrong press was issued.
    task automatic input_round(input int r, input int fr, input int fs,
                               output bit lost);
        bit good;
        lost = 0;
        for (int p = 0; p < r; p++) begin
            repeat ($urandom_range(0, 3)) begin
                pulse = rbit();
                @(negedge clk);
            end
            good = !(r == fr && p == fs);
            if (!good) push_end(2, r);
            else if (r == N && p == r - 1) push_end(1, r);
            pulse     = rbit();
            btn_valid = 1'b1;
            result    = good;
            @(negedge clk);
            btn_valid = 1'b0;
            pulse     = 1'b0;
            @(negedge clk);
            result = rbit();
            if (!good) begin
                lost = 1;
                return;
            end
        end
    endtask

    task automatic end_game(input int ew, input int er);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (win || lose) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            fail_now("end_wait");
            return;
        end
        repeat (3) begin
            btn_valid = rbit();
            pulse     = rbit();
            result    = rbit();
            @(negedge clk);
            chk("hold_win", int'(win), ew);
            chk("hold_lose", int'(lose), 1 - ew);
            chk("hold_busy", int'(busy), 0);
            chk("hold_round", int'(check_round), er);
        end
        btn_valid = 1'b0;
        pulse     = 1'b0;
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
        chk("idle_seed", int'(rst_seedgen), 1);
        chk("idle_busy", int'(busy), 0);
        chk("idle_end", int'(win | lose), 0);
        repeat ($urandom_range(1, 3)) begin
            btn_valid = rbit();
            pulse     = rbit();
            @(negedge clk);
        end
        btn_valid = 1'b0;
        pulse     = 1'b0;
        chk("idle_stays", int'(busy), 0);
    endtask

    // fr=0: play to a win. abort_r>0: reset during that round's first flash.
    task automatic play_game(input int fr, input int fs, input int abort_r);
        bit ok;
        bit lost;
        if (stop_all) return;
        push_round(1);
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
        for (int r = 1; r <= N; r++) begin
            if (r > 1) push_round(r);
            show_round(r, r == abort_r, ok);
            if (!ok) return;
            input_round(r, fr, fs, lost);
            if (lost) begin
                end_game(0, r);
                return;
            end
        end
        end_game(1, N);
    endtask

    initial begin
        int fr;
        rst_n     = 1'b0;
        start_btn = 1'b0;
        btn_valid = 1'b0;
        result    = 1'b0;
        pulse     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_seed", int'(rst_seedgen), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_round", int'(check_round), 0);
        chk("reset_step", int'(step_idx), 0);
        chk("reset_speed", int'(speed), 0);
        chk("reset_flash", int'(flash_clk), 0);
        chk("reset_start", int'(start), 0);
        chk("reset_load", int'(load_colour), 0);
        chk("reset_winlose", int'(win | lose), 0);
        rst_n = 1'b1;
        play_game(2, 1, 0);
        play_game(0, 0, 3);
        play_game(0, 0, 0);
        for (int g = 0; g < 8; g++) begin
            fr = $urandom_range(1, N);
            if ($urandom_range(0, 3) == 0) fr = 0;
            play_game(fr, (fr > 0) ? $urandom_range(0, fr - 1) : 0, 0);
        end
`ifdef SIMON_TIMEOUT_EN
        if (!stop_all) begin : timeout_test
            bit ok;
            push_round(1);
            start_btn = 1'b1;
            @(negedge clk);
            start_btn = 1'b0;
            show_round(1, 1'b0, ok);
            if (ok) begin
                repeat (7) begin
                    pulse = 1'b1;
                    @(negedge clk);
                end
                pulse     = 1'b1;
                btn_valid = 1'b1;
                result    = 1'b1;
                @(negedge clk);
                pulse     = 1'b0;
                btn_valid = 1'b0;
                @(negedge clk);
                push_round(2);
                show_round(2, 1'b0, ok);
            end
            if (ok) begin
                repeat (7) begin
                    pulse = 1'b1;
                    @(negedge clk);
                end
                pulse = 1'b0;
                chk("to_not_yet", int'(lose), 0);
                chk("to_busy", int'(busy), 1);
                push_end(2, 2);
                pulse = 1'b1;
                @(negedge clk);
                pulse = 1'b0;
                chk("to_lose", int'(lose), 1);
                end_game(0, 2);
            end
        end
`endif
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/simon_seq_fsm.md
SIMON_SEQ_FSM -- requirements
Module: simon_seq_fsm

Interface
REQ-001 SHALL have parameter N_ROUNDS, default 32: number of rounds needed to win (legal range 2..255).
REQ-002 SHALL have parameter ROUND_W, default 6: width of the round and step counters; 2**ROUND_W > N_ROUNDS.
REQ-003 SHALL have parameter SPEED_W, default 3: width of the speed level; speed saturates at 2**SPEED_W-1.
REQ-004 SHALL have parameter ROUNDS_PER_SPEED, default 4: number of completed rounds between speed increments.
REQ-005 SHALL have port clk, in, 1: the single clock.
REQ-006 SHALL have port rst_n, in, 1: reset, asynchronous and active-low.
REQ-007 SHALL have inputs start_btn (1), btn_valid (1, player press strobe), result (1, press matched), pulse (1, flash-timer tick).
REQ-008 SHALL have outputs start, load_colour, load_speed, rst_seedgen, flash_clk (1 each); check_round (ROUND_W); step_idx (ROUND_W); speed (SPEED_W); win, lose, busy (1 each).

Function
REQ-009 SHALL implement the states IDLE, LOAD, SHOW_ON, SHOW_OFF, INPUT, CHECK, NEXT, WIN and LOSE, with all outputs registered.
REQ-010 IDLE: rst_seedgen=1 and busy=0; when start_btn=1, SHALL pulse start for 1 cycle, set check_round=1, step_idx=0, speed=0, and go to LOAD.
REQ-011 LOAD: SHALL pulse load_colour and load_speed for exactly 1 cycle, then go to SHOW_ON.
REQ-012 SHOW_ON: flash_clk=1; when pulse=1, SHALL go to SHOW_OFF.
REQ-013 SHOW_OFF: flash_clk=0; when pulse=1 and step_idx==check_round-1, SHALL set step_idx=0 and go to INPUT; when pulse=1 otherwise, SHALL increment step_idx and go to LOAD.
REQ-014 INPUT: when btn_valid=1, SHALL go to CHECK next cycle; if btn_valid and pulse are both 1 in the same cycle, btn_valid SHALL win.
REQ-015 CHECK (1 cycle): result=0 SHALL go to LOSE.
REQ-016 CHECK with result=1: if step_idx<check_round-1, SHALL increment step_idx and return to INPUT; else if check_round==N_ROUNDS, SHALL go to WIN; else SHALL go to NEXT.
REQ-017 NEXT (1 cycle): SHALL increment check_round and set step_idx=0; when the new check_round is a multiple of ROUNDS_PER_SPEED, SHALL increment speed, saturating; then SHALL go to LOAD.
REQ-018 WIN/LOSE: win or lose SHALL be held at 1; start_btn=1 SHALL return to IDLE; all other inputs SHALL be ignored.
REQ-019 start_btn SHALL be ignored in every state except IDLE, WIN and LOSE.
REQ-020 busy SHALL be 1 in every state except IDLE, WIN and LOSE.
REQ-021 btn_valid SHALL be ignored outside INPUT; pulse SHALL be ignored outside SHOW_ON and SHOW_OFF, except as stated in REQ-024.

Reset
REQ-022 While rst_n=0, SHALL hold state=IDLE, rst_seedgen=1, all other outputs 0, and all counters 0, including when reset is asserted mid-round.
REQ-023 After deassertion, SHALL accept start_btn on the first rising clk edge.

Configuration
REQ-024 With SIMON_TIMEOUT_EN defined, INPUT SHALL count pulse ticks, reset the count on entry and on each btn_valid, and go to LOSE when the count reaches parameter TIMEOUT_PULSES (default 8).
REQ-025 Without SIMON_TIMEOUT_EN, there SHALL be no timeout counter or TIMEOUT_PULSES parameter, and INPUT SHALL wait indefinitely.

Structure
REQ-026 Package simon_pkg SHALL hold the state enum typedef and the default values for N_ROUNDS, SPEED_W and ROUNDS_PER_SPEED.
REQ-027 The speed saturation and ramp logic SHALL be a sub-module, simon_speed_ramp, with inputs clk, rst_n, clr, inc_round and output speed.

Verification
REQ-028 Reset mid-SHOW_ON (round 3) -> next cycle IDLE, rst_seedgen=1, check_round=0, flash_clk=0.
REQ-029 start_btn, then 2 pulses, then btn_valid with result=1 -> start and load pulses, round 1 flashed once, NEXT, check_round=2.
REQ-030 N_ROUNDS=3, correct presses throughout -> win=1 after 6 CHECK cycles with result=1; then start_btn -> IDLE.
REQ-031 Round 2, second press with result=0 -> LOSE, lose=1, check_round=2 held.
REQ-032 ROUNDS_PER_SPEED=1, SPEED_W=2, 6 rounds -> speed sequence 1,2,3,3,3.
REQ-033 SIMON_TIMEOUT_EN defined, TIMEOUT_PULSES=8, 8 pulses in INPUT with no press -> LOSE; btn_valid and pulse in the same cycle -> CHECK taken.
